// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types, default geometry and sizing helpers for word_serializer_64.
//   Provides the IDLE/SEND state enum, default WORD_W/BEAT_W, BEATS and CNT_W,
//   a counter-width helper and the word/beat divisibility check used at elaboration.
package serializer_pkg;
    typedef enum logic {IDLE, SEND} state_e;
    function automatic int cnt_w(input int beats);
        return beats > 1 ? $clog2(beats) : 1;
    endfunction
    function automatic bit width_ok(input int word_w, input int beat_w);
        return beat_w > 0 && word_w >= beat_w && word_w % beat_w == 0;
    endfunction
    localparam int WORD_W_DEF = 64;
    localparam int BEAT_W_DEF = 8;
    localparam int BEATS      = WORD_W_DEF / BEAT_W_DEF;
    localparam int CNT_W      = cnt_w(BEATS);
endpackage

// File: rtl/word_serializer_64_beat_counter.sv
// beat_counter: beat index counter with enable, synchronous clear and terminal-count flag.
//   clk    in  clock
//   reset  in  asynchronous active-low reset, clears the count
//   clr_i  in  synchronous clear (wins over en_i)
//   en_i   in  increment by one
//   tc_o   out count equals LAST
module beat_counter #(
    parameter int W    = 3,
    parameter int LAST = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + W'(1);
    end
    assign tc_o = cnt_q == W'(LAST);
endmodule

// File: rtl/word_serializer_64.sv
// word_serializer_64: loads a word over valid/ready and streams it out as BEAT_W-wide beats.
//   clk/reset              clock, asynchronous active-low reset
//   load_valid/load_data   word offered for serialization
//   load_ready             word accepted this cycle (idle, or final beat handshaking)
//   beat_valid/beat_data   current beat, LSB beat first unless MSB_FIRST
//   beat_ready             downstream takes the beat
//   beat_last              current beat is the word's final beat
//   busy                   a word is held and not yet fully sent
module word_serializer_64
    import serializer_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int BEAT_W    = BEAT_W_DEF,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    output logic              load_ready,
    output logic              beat_valid,
    output logic [BEAT_W-1:0] beat_data,
    input  logic              beat_ready,
    output logic              beat_last,
    output logic              busy
);
    localparam int NB = WORD_W / BEAT_W;
    localparam int CW = cnt_w(NB);
    if (!width_ok(WORD_W, BEAT_W)) begin : g_bad_width
        $error("word_serializer_64: WORD_W must be a multiple of BEAT_W");
    end
    state_e            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              tc, fire, done, accept;
    assign busy       = state_q == SEND;
    assign beat_valid = busy;
    assign beat_last  = busy & tc;
    assign fire       = beat_valid & beat_ready;
    assign done       = fire & beat_last;
    // A new word may enter on the very cycle the final beat leaves, giving gapless words.
    assign load_ready = !busy | done;
    assign accept     = load_valid & load_ready;
    assign beat_data  = MSB_FIRST ? shift_q[WORD_W-1 -: BEAT_W] : shift_q[BEAT_W-1:0];
    always_comb begin
        shift_d = accept ? load_data : fire ? (MSB_FIRST ? shift_q << BEAT_W : shift_q >> BEAT_W) : shift_q;
        state_d = accept ? SEND : done ? IDLE : state_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end
    // Counter holds at the last index after a word ends; only a load returns it to zero.
    beat_counter #(.W(CW), .LAST(NB - 1)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr_i(accept),
        .en_i (fire & !tc),
        .tc_o (tc)
    );
endmodule

// File: tb/tb_word_serializer_64.sv
// tb_word_serializer_64: scoreboard bench for LSB-first and MSB-first serializer instances.
module tb_word_serializer_64;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lv[2], lr[2], bv[2], br[2], bl[2], bz[2];
    logic [63:0] ld[2];
    logic [7:0]  bd[2];
    bit          stall_en[2];
    int          checks = 0;
    int          failures = 0;
    always #5 clk = ~clk;
    word_serializer_64 #(.MSB_FIRST(1'b0)) dut (
        .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr[0]),
        .beat_valid(bv[0]), .beat_data(bd[0]), .beat_ready(br[0]), .beat_last(bl[0]), .busy(bz[0])
    );
    word_serializer_64 #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr[1]),
        .beat_valid(bv[1]), .beat_data(bd[1]), .beat_ready(br[1]), .beat_last(bl[1]), .busy(bz[1])
    );
    function automatic void chk(input string n, input int i, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s dut%0d got=%h exp=%h t=%0t", n, i, a, e, $time);
        end
    endfunction
    // Reference model: the queue holds the beats still owed for the current word.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic [7:0] q[$];
        always @(negedge clk) begin
            bit          er;
            logic [63:0] w;
            if (!reset) begin
                q.delete();
                chk("rst_load_ready", g, 64'(lr[g]), 64'd1);
                chk("rst_beat_valid", g, 64'(bv[g]), 64'd0);
                chk("rst_busy", g, 64'(bz[g]), 64'd0);
                chk("rst_beat_last", g, 64'(bl[g]), 64'd0);
                chk("rst_beat_data", g, 64'(bd[g]), 64'd0);
            end else begin
                er = q.size() == 0 || (q.size() == 1 && br[g]);
                chk("load_ready", g, 64'(lr[g]), 64'(er));
                chk("beat_valid", g, 64'(bv[g]), 64'(q.size() != 0));
                chk("busy", g, 64'(bz[g]), 64'(q.size() != 0));
                chk("beat_last", g, 64'(bl[g]), 64'(q.size() == 1));
                if (q.size() != 0) chk("beat_data", g, 64'(bd[g]), 64'(q[0]));
                if (q.size() != 0 && br[g]) void'(q.pop_front());
                if (lv[g] && er) begin
                    w = ld[g];
                    for (int k = 0; k < 8; k++) q.push_back(g == 1 ? w[8*(7-k) +: 8] : w[8*k +: 8]);
                end
            end
        end
    end
    initial begin
        br[0] = 1'b1;
        br[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) br[i] = stall_en[i] ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask
    task automatic send_word(input int i, input logic [63:0] w);
        bit acc;
        int n;
        lv[i] = 1'b1;
        ld[i] = w;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = lr[i];
            edge1();
            n++;
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL load_timeout dut%0d got=not_accepted exp=accepted", i);
        end
        lv[i] = 1'b0;
    endtask
    task automatic wait_idle(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bz[i] && n < 500);
        checks++;
        if (bz[i]) begin
            failures++;
            $display("FAIL idle_timeout dut%0d got=busy exp=idle", i);
        end
        edge1();
    endtask
    initial begin
        for (int i = 0; i < 2; i++) begin
            lv[i] = 1'b0;
            ld[i] = '0;
            stall_en[i] = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_load_ready", i, 64'(lr[i]), 64'd1);
            chk("async_rst_beat_valid", i, 64'(bv[i]), 64'd0);
            chk("async_rst_busy", i, 64'(bz[i]), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        send_word(0, 64'h0123_4567_89AB_CDEF);
        wait_idle(0);
        chk("idle_load_ready", 0, 64'(lr[0]), 64'd1);
        send_word(1, 64'h0123_4567_89AB_CDEF);
        wait_idle(1);
        stall_en[0] = 1'b1;
        send_word(0, 64'h0123_4567_89AB_CDEF);
        wait_idle(0);
        stall_en[0] = 1'b0;
        send_word(0, {8{8'h11}});
        send_word(0, {8{8'h22}});
        wait_idle(0);
        send_word(0, 64'h0);
        repeat (3) edge1();
        send_word(0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle(0);
        send_word(0, 64'hDEAD_BEEF_CAFE_F00D);
        repeat (4) edge1();
        #2 reset = 1'b0;
        #1;
        chk("midword_rst_beat_valid", 0, 64'(bv[0]), 64'd0);
        chk("midword_rst_busy", 0, 64'(bz[0]), 64'd0);
        chk("midword_rst_load_ready", 0, 64'(lr[0]), 64'd1);
        edge1();
        reset = 1'b1;
        repeat (2) edge1();
        send_word(0, 64'h0123_4567_89AB_CDEF);
        wait_idle(0);
        for (int r = 0; r < 40; r++) begin
            stall_en[0] = 1'($urandom_range(0, 1));
            stall_en[1] = 1'($urandom_range(0, 1));
            send_word(r % 2, {$urandom, $urandom});
            repeat ($urandom_range(0, 3)) edge1();
        end
        stall_en[0] = 1'b0;
        stall_en[1] = 1'b0;
        wait_idle(0);
        wait_idle(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #400000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/word_serializer_64.md
# word_serializer_64

Reads a 64-bit register value through a valid/ready load port and transmits it as eight 8-bit beats on a valid/ready stream port, least-significant beat first by default. It is the read-out end of the 64-bit register datapath, used wherever a stored word (wheel state, bet totals, RNG seed) has to cross a narrow byte-wide link to the display or UART front end. It supports back-to-back words with no idle cycle between them.

## Interface
- WORD_W, 64, width of the loaded word; must be an integer multiple of BEAT_W
- BEAT_W, 8, width of each transmitted beat
- MSB_FIRST, 0, 0 = beat 0 carries word bits [7:0]; 1 = beat 0 carries word bits [63:56]

- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- load_valid  input  1  load_data is presented
- load_data  input  WORD_W  word to serialize
- load_ready  output  1  block accepts a word this cycle
- beat_valid  output  1  beat_data is valid
- beat_data  output  BEAT_W  current beat
- beat_ready  input  1  downstream accepts the beat this cycle
- beat_last  output  1  current beat is the final beat of the word
- busy  output  1  a word is held and not fully sent

## Operation
- States: IDLE and SEND.
- IDLE:
  - load_ready=1, beat_valid=0.
  - load_valid&load_ready -> capture load_data into the shift register, clear the beat counter, go to SEND.
- SEND:
  - beat_valid=1; beat_data = low BEAT_W bits of the shift register (high bits when MSB_FIRST=1).
  - On beat_valid&beat_ready, shift by BEAT_W and increment the counter.
  - beat_last=1 when counter == BEATS-1, where BEATS = WORD_W/BEAT_W = 8.
- Final-beat handshake (beat_last&beat_ready):
  - load_valid=1 -> capture the new word, counter to 0, stay in SEND (no bubble).
  - Otherwise -> IDLE.
- load_ready = IDLE | (SEND & beat_last & beat_ready). This is the only combinational path from beat_ready to load_ready.
- beat_data and beat_valid are stable while beat_valid=1 and beat_ready=0. Downstream may hold beat_ready low indefinitely.
- A load attempt in SEND before the final-beat handshake is not accepted. load_ready=0, and the held word is untouched.
- busy = (state == SEND).
- Counter width is clog2(BEATS). It never exceeds BEATS-1, and wraps to 0 only through a load.

## Timing
- Reset values, asserted immediately on reset low with no clock required:
  - state=IDLE, counter=0, shift register=0
  - beat_valid=0, beat_last=0, busy=0, beat_data=0, load_ready=1
- Release of reset is synchronous to the next rising edge.
- Latency: load accepted at edge T -> beat 0 valid after T, so visible in cycle T+1.
- With beat_ready held high, beat k is accepted at edge T+1+k and beat_last is high in cycle T+8.
- Throughput: 8 cycles per word when load_valid and beat_ready are held high.
- Reset low mid-word aborts the word. No partial beats are emitted after reset deasserts.

## Structure
- Shared package `serializer_pkg`:
  - state enum (IDLE, SEND)
  - localparams BEATS and CNT_W
  - elaboration check that WORD_W % BEAT_W == 0
- One natural sub-module: `beat_counter`. It is a CNT_W-bit counter with enable, synchronous clear, terminal-count output, and asynchronous active-low reset.
- The shift register and FSM stay in the top module.

## Test plan
- Reset then single word:
  - Stimulus: load 64'h0123_4567_89AB_CDEF with beat_ready=1.
  - Required: beats EF,CD,AB,89,67,45,23,01 on 8 consecutive cycles; beat_last only on 01; then IDLE with load_ready=1.
- Back-pressure:
  - Stimulus: same word, beat_ready toggled 1,0,0,1,... with random stalls.
  - Required: beat_data is held constant during each stall; order and count are unchanged; busy=1 throughout.
- Back-to-back words:
  - Stimulus: load_valid held high with words A=64'h1111_..._11 then B=64'h2222_..._22.
  - Required: 16 consecutive beats (eight 11 then eight 22) with no idle cycle; load_ready pulses only on A's final beat.
- Load during SEND:
  - Stimulus: load_valid=1 with 64'hFFFF_FFFF_FFFF_FFFF at beat 3 of word 64'h0.
  - Required: load_ready=0; word 0 completes with all beats 00; the new word is accepted only at the final-beat handshake.
- Reset mid-operation:
  - Stimulus: assert reset low at beat 4 between clock edges.
  - Required: beat_valid=0 and busy=0 immediately; after release, no stale beats appear; the next load starts at beat 0.
- MSB_FIRST=1:
  - Stimulus: load 64'h0123_4567_89AB_CDEF.
  - Required: beats 01,23,45,67,89,AB,CD,EF.
